// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES SubBytes engine
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subbytes_state_t;

    typedef logic [7:0] aes_byte_t;

    localparam int AES_STATE_BYTES = 16;

    // Width of a counter able to hold 0..count-1, never narrower than one bit
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// rtl/aes_subbytes_seq_if.sv - start/result handshake bundle of the SubBytes engine
interface aes_subbytes_seq_if
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = AES_STATE_BYTES
);

    logic                   start;
    logic                   inverse;
    logic [8*NUM_BYTES-1:0] data_in;
    logic                   busy;
    logic                   done;
    logic [8*NUM_BYTES-1:0] data_out;

    // Requester side: the round controller
    modport master (
        output start,
        output inverse,
        output data_in,
        input  busy,
        input  done,
        input  data_out
    );

    // Engine side
    modport slave (
        input  start,
        input  inverse,
        input  data_in,
        output busy,
        output done,
        output data_out
    );

endinterface

// File: rtl/aes_sbox_lut.sv
// rtl/aes_sbox_lut.sv - combinational forward/inverse AES S-box lookup
module aes_sbox_lut
    import aes_pkg::*;
(
    input  aes_byte_t in,
    input  logic      inverse,
    output aes_byte_t out
);

    localparam aes_byte_t FWD_TBL [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_TBL [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Both tables are read every cycle; the mode bit only steers the output mux
    assign out = inverse ? INV_TBL[in] : FWD_TBL[in];

endmodule

// File: rtl/aes_subbytes_seq.sv
// rtl/aes_subbytes_seq.sv - multi-cycle AES SubBytes engine, LANES bytes per clock
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = AES_STATE_BYTES,
    parameter int LANES     = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    aes_subbytes_seq_if.slave  bus
);

    localparam int K  = NUM_BYTES / LANES;
    localparam int CW = cnt_width(K);
    localparam int W  = 8 * NUM_BYTES;
    localparam int LW = 8 * LANES;

    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // An uneven lane split would leave bytes unsubstituted; refuse to build it
    if (LANES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be >= 1 and divide NUM_BYTES");
    end

    subbytes_state_t state_q;
    logic [CW-1:0]   cnt_q;
    logic            mode_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    out_q;

    int              base;
    logic [LW-1:0]   lane_in;
    logic [LW-1:0]   lane_out;
    logic [W-1:0]    work_d;
    logic            last_pass;

    // Byte window of the current pass within the working state
    assign base      = int'(cnt_q) * LW;
    assign lane_in   = work_q[base +: LW];
    assign last_pass = (cnt_q == CNT_LAST);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lut u_lut (
            .in      (lane_in[8*g +: 8]),
            .inverse (mode_q),
            .out     (lane_out[8*g +: 8])
        );
    end

    // Working state with the current window replaced by its substitutes
    always_comb begin
        work_d = work_q;
        work_d[base +: LW] = lane_out;
    end

    // Capture, per-pass substitution and result publication
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        work_q  <= bus.data_in;
                        mode_q  <= bus.inverse;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (last_pass) begin
                        // data_out only ever sees a fully substituted state
                        out_q   <= work_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = out_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb/tb_aes_subbytes_seq.sv - self-checking bench for aes_subbytes_seq
module tb_aes_subbytes_seq;
    import aes_pkg::*;

    localparam int NB = 16;
    localparam int LN = 4;
    localparam int K  = NB / LN;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start = 1'b0;
    logic         inverse = 1'b0;
    logic [W-1:0] data_in = '0;

    always #5 clk = ~clk;

    aes_subbytes_seq_if #(.NUM_BYTES(NB)) m_bus ();
    assign m_bus.start   = start;
    assign m_bus.inverse = inverse;
    assign m_bus.data_in = data_in;

    aes_subbytes_seq #(.NUM_BYTES(NB), .LANES(LN)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (m_bus)
    );

    logic [2:0]   sw_start = '0;
    logic [2:0]   sw_done;
    logic [2:0]   sw_busy;
    logic [W-1:0] sw_out [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        aes_subbytes_seq_if #(.NUM_BYTES(NB)) s_bus ();
        assign s_bus.start   = sw_start[g];
        assign s_bus.inverse = inverse;
        assign s_bus.data_in = data_in;
        assign sw_done[g]    = s_bus.done;
        assign sw_busy[g]    = s_bus.busy;
        assign sw_out[g]     = s_bus.data_out;
        aes_subbytes_seq #(.NUM_BYTES(NB), .LANES((g == 0) ? 1 : ((g == 1) ? 2 : 16))) dut (
            .clk   (clk),
            .n_rst (n_rst),
            .bus   (s_bus)
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference S-boxes derived from GF(2^8) inversion plus the affine map
    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            fwd_m[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
    endtask

    function automatic logic [W-1:0] sub_all(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
        return r;
    endfunction

    // Transaction model: capture time stamps and results, no engine internals
    int           cyc = 0;
    bit           act = 1'b0;
    int           cap = 0;
    logic [W-1:0] pend = '0;
    logic [W-1:0] last = '0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            act  = 1'b0;
            pend = '0;
            last = '0;
        end else begin
            cyc++;
            if (start && !(act && (cyc - 1) < cap + K)) begin
                if (act) last = pend;
                pend = sub_all(data_in, inverse);
                cap  = cyc;
                act  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic         e_busy;
        logic         e_done;
        logic [W-1:0] e_out;
        if (!n_rst) begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_out  = '0;
        end else begin
            e_busy = act && cyc >= cap && cyc < cap + K;
            e_done = act && cyc == cap + K;
            e_out  = (act && cyc >= cap + K) ? pend : last;
        end
        check("cyc_busy", W'(m_bus.busy), W'(e_busy));
        check("cyc_done", W'(m_bus.done), W'(e_done));
        check("cyc_data_out", m_bus.data_out, e_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the main engine's done; returns cycles since capture and busy samples
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!m_bus.done && lat < 64) begin
            busy_cnt += int'(m_bus.busy);
            step();
            lat++;
        end
    endtask

    task automatic run_one(input logic [W-1:0] d, input logic inv, output int lat, output int busy_cnt);
        data_in = d;
        inverse = inv;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_done(lat, busy_cnt);
    endtask

    logic [7:0]   inc_exp_b [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                                     8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
    logic [W-1:0] inc_vec;
    logic [W-1:0] inc_exp;
    logic [W-1:0] vec_a;
    logic [W-1:0] vec_b;
    int           lat;
    int           bcnt;
    int           dpos [$];
    int           lat_exp [3] = '{16, 8, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        build_tables();
        for (int i = 0; i < NB; i++) begin
            inc_vec[8*i +: 8] = 8'(i);
            inc_exp[8*i +: 8] = inc_exp_b[i];
        end

        check("pin_fwd_00", W'(fwd_m[8'h00]), W'(8'h63));
        check("pin_fwd_inc", sub_all(inc_vec, 1'b0), inc_exp);
        check("pin_inv_ed", W'(inv_m[8'hed]), W'(8'h53));
        check("pin_inv_16", W'(inv_m[8'h16]), W'(8'hff));

        #2 n_rst = 1'b0;
        step();
        step();
        check("reset_busy", W'(m_bus.busy), '0);
        check("reset_done", W'(m_bus.done), '0);
        check("reset_data_out", m_bus.data_out, '0);
        n_rst = 1'b1;
        step();

        run_one('0, 1'b0, lat, bcnt);
        check("zero_latency", W'(lat), W'(K));
        check("zero_busy_cycles", W'(bcnt), W'(K));
        check("zero_data_out", m_bus.data_out, {NB{8'h63}});
        step();

        run_one(inc_vec, 1'b0, lat, bcnt);
        check("inc_latency", W'(lat), W'(K));
        check("inc_data_out", m_bus.data_out, inc_exp);
        step();

        run_one(inc_exp, 1'b1, lat, bcnt);
        check("inv_roundtrip", m_bus.data_out, inc_vec);
        step();

        vec_a = {$urandom, $urandom, $urandom, $urandom};
        vec_a[15:0] = 16'h16ed;
        run_one(vec_a, 1'b1, lat, bcnt);
        check("inv_spot_ed", W'(m_bus.data_out[7:0]), W'(8'h53));
        check("inv_spot_16", W'(m_bus.data_out[15:8]), W'(8'hff));
        step();

        // New request while the engine is busy must be dropped
        data_in = inc_vec;
        inverse = 1'b0;
        start   = 1'b1;
        step();
        data_in = {NB{8'hff}};
        step();
        step();
        start   = 1'b0;
        lat = 2;
        bcnt = 0;
        while (!m_bus.done && lat < 64) begin
            step();
            lat++;
        end
        check("run_start_latency", W'(lat), W'(K));
        check("run_start_data_out", m_bus.data_out, inc_exp);
        step();
        run_one({NB{8'hff}}, 1'b0, lat, bcnt);
        check("ff_data_out", m_bus.data_out, {NB{8'h16}});
        step();

        // Back-to-back with start held through DONE
        vec_a = {$urandom, $urandom, $urandom, $urandom};
        vec_b = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            data_in = (i % 2 == 0) ? vec_a : vec_b;
            inverse = 1'($urandom_range(0, 1));
            step();
            if (m_bus.done) dpos.push_back(i);
        end
        start = 1'b0;
        check("b2b_pulse_count", W'(dpos.size() >= 3), W'(1));
        for (int i = 1; i < dpos.size(); i++)
            check("b2b_spacing", W'(dpos[i] - dpos[i-1]), W'(K + 1));
        repeat (3) step();

        // Abort in mid-transaction
        run_one(inc_vec, 1'b0, lat, bcnt);
        step();
        data_in = vec_a;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_rst = 1'b0;
        #1;
        check("abort_busy", W'(m_bus.busy), '0);
        check("abort_done", W'(m_bus.done), '0);
        check("abort_data_out", m_bus.data_out, '0);
        step();
        n_rst = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            bcnt += int'(m_bus.done);
        end
        check("abort_no_done", W'(bcnt), '0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            inverse = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 9) < 4);
            n_rst   = ($urandom_range(0, 99) != 0);
            step();
        end
        n_rst = 1'b1;
        start = 1'b0;
        repeat (K + 2) step();

        // Lane-count sweep on the incrementing vector
        for (int g = 0; g < 3; g++) begin
            data_in = inc_vec;
            inverse = 1'b0;
            sw_start[g] = 1'b1;
            step();
            sw_start[g] = 1'b0;
            check("sweep_busy", W'(sw_busy[g]), W'(1));
            lat = 0;
            while (!sw_done[g] && lat < 64) begin
                step();
                lat++;
            end
            check("sweep_latency", W'(lat), W'(lat_exp[g]));
            check("sweep_data_out", sw_out[g], inc_exp);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
